// File: rtl/useq_pkg.sv
// Shared constants for the microinstruction fetch stage: am2910 opcodes,
// microword field widths and fetch FSM state encodings.
package useq_pkg;

  localparam logic [3:0] OpJz   = 4'd0;
  localparam logic [3:0] OpCjs  = 4'd1;
  localparam logic [3:0] OpJmap = 4'd2;
  localparam logic [3:0] OpCjp  = 4'd3;
  localparam logic [3:0] OpPush = 4'd4;
  localparam logic [3:0] OpJsrp = 4'd5;
  localparam logic [3:0] OpCjv  = 4'd6;
  localparam logic [3:0] OpJrp  = 4'd7;
  localparam logic [3:0] OpRfct = 4'd8;
  localparam logic [3:0] OpRpct = 4'd9;
  localparam logic [3:0] OpCrtn = 4'd10;
  localparam logic [3:0] OpCjpp = 4'd11;
  localparam logic [3:0] OpLdct = 4'd12;
  localparam logic [3:0] OpLoop = 4'd13;
  localparam logic [3:0] OpCont = 4'd14;
  localparam logic [3:0] OpTwb  = 4'd15;

  // Microword layout, LSB first: d, i, ccen_bar, cc_sel.
  localparam int unsigned DLsb       = 0;
  localparam int unsigned IWidth     = 4;
  localparam int unsigned CcenWidth  = 1;
  localparam int unsigned FixedWidth = IWidth + CcenWidth;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StLoad = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

endpackage

// File: rtl/useq_cc_mux.sv
// Condition-code select: picks one live status flag and presents it active-low.
module useq_cc_mux
  import useq_pkg::*;
#(
  parameter int unsigned CC_SEL_W = 3
) (
  input  logic [CC_SEL_W-1:0]    cc_sel,
  input  logic [2**CC_SEL_W-1:0] status,
  output logic                   cc_bar
);

  assign cc_bar = ~status[cc_sel];

endmodule

// File: rtl/useq_fetch_stage.sv
// Microinstruction fetch and pipeline register in front of an am2910-style sequencer.
// Build option USEQ_FETCH_PARITY_EN adds an even-parity MSB on mem_rdata and a sticky par_err.
module useq_fetch_stage
  import useq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned CC_SEL_W = 3,
  localparam int unsigned WORD_W  = DATA_W + CC_SEL_W + 5,
`ifdef USEQ_FETCH_PARITY_EN
  localparam int unsigned RD_W    = WORD_W + 1
`else
  localparam int unsigned RD_W    = WORD_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      y_addr,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [RD_W-1:0]        mem_rdata,
  input  logic [2**CC_SEL_W-1:0] status,
  input  logic                   hold,
  output logic [3:0]             I,
  output logic                   CCEN_BAR,
  output logic                   CC_BAR,
  output logic [DATA_W-1:0]      D,
  output logic                   seq_ce,
`ifdef USEQ_FETCH_PARITY_EN
  output logic                   par_err,
`endif
  output logic                   uinst_valid
);

  localparam int unsigned ILsb    = DLsb + DATA_W;
  localparam int unsigned CcenBit = ILsb + IWidth;
  localparam int unsigned CcLsb   = CcenBit + CcenWidth;

  logic [1:0]          state_q, state_d;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          i_q;
  logic                ccen_q;
  logic [DATA_W-1:0]   d_q;
  logic [CC_SEL_W-1:0] cc_sel_q;
  logic                valid_q;
  logic                issue, capture, word_ok;
  logic [WORD_W-1:0]   word;

  assign word = mem_rdata[WORD_W-1:0];

`ifdef USEQ_FETCH_PARITY_EN
  assign word_ok = ~(^mem_rdata);
`else
  assign word_ok = 1'b1;
`endif

  // issue: latch y_addr and raise mem_req; capture: load the returned word.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StReq;
        issue   = 1'b1;
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StLoad;
          capture = 1'b1;
        end
      end
      StLoad: begin
        if (hold) begin
          state_d = StHold;
        end else begin
          state_d = StReq;
          issue   = 1'b1;
        end
      end
      StHold: begin
        if (!hold) begin
          state_d = StReq;
          issue   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      i_q        <= OpJz;
      ccen_q     <= 1'b1;
      d_q        <= '0;
      cc_sel_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= y_addr;
      end else if (capture) begin
        mem_req_q <= 1'b0;
      end
      if (capture) begin
        valid_q <= 1'b1;
        if (word_ok) begin
          i_q      <= word[ILsb +: IWidth];
          ccen_q   <= word[CcenBit];
          d_q      <= word[DLsb +: DATA_W];
          cc_sel_q <= word[CcLsb +: CC_SEL_W];
        end else begin
          // Corrupt word becomes a harmless CONT so the sequencer just steps past it.
          i_q      <= OpCont;
          ccen_q   <= 1'b1;
          d_q      <= '0;
          cc_sel_q <= '0;
        end
      end
    end
  end

`ifdef USEQ_FETCH_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (capture && !word_ok) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`endif

  useq_cc_mux #(
    .CC_SEL_W (CC_SEL_W)
  ) u_cc_mux (
    .cc_sel (cc_sel_q),
    .status (status),
    .cc_bar (CC_BAR)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign I           = i_q;
  assign CCEN_BAR    = ccen_q;
  assign D           = d_q;
  assign seq_ce      = (state_q == StLoad);
  assign uinst_valid = valid_q;

endmodule

// File: tb/tb_useq_fetch_stage.sv
// Self-checking bench for useq_fetch_stage; loaded words are scoreboarded and
// compared when seq_ce pulses. Honours USEQ_FETCH_PARITY_EN.
module tb_useq_fetch_stage;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int CC_W   = 3;
  localparam int WORD_W = DATA_W + CC_W + 5;
`ifdef USEQ_FETCH_PARITY_EN
  localparam int RD_W   = WORD_W + 1;
`else
  localparam int RD_W   = WORD_W;
`endif

  typedef struct packed {
    logic [3:0]        i;
    logic              ccen;
    logic [CC_W-1:0]   cc;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] y_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [RD_W-1:0]   mem_rdata;
  logic [7:0]        status;
  logic              hold;
  logic [3:0]        I;
  logic              CCEN_BAR;
  logic              CC_BAR;
  logic [DATA_W-1:0] D;
  logic              seq_ce;
  logic              uinst_valid;
`ifdef USEQ_FETCH_PARITY_EN
  logic              par_err;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  useq_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .y_addr      (y_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .status      (status),
    .hold        (hold),
    .I           (I),
    .CCEN_BAR    (CCEN_BAR),
    .CC_BAR      (CC_BAR),
    .D           (D),
    .seq_ce      (seq_ce),
`ifdef USEQ_FETCH_PARITY_EN
    .par_err     (par_err),
`endif
    .uinst_valid (uinst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [RD_W-1:0] mk(input logic [CC_W-1:0] cc, input logic ccen,
                                         input logic [3:0] i, input logic [DATA_W-1:0] d);
    logic [WORD_W-1:0] w;
    w = {cc, ccen, i, d};
`ifdef USEQ_FETCH_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ack_word(input logic [CC_W-1:0] cc, input logic ccen, input logic [3:0] i,
                          input logic [DATA_W-1:0] d);
    mem_ack   = 1'b1;
    mem_rdata = mk(cc, ccen, i, d);
    sb.push_back('{i: i, ccen: ccen, cc: cc, d: d});
  endtask

  // Scoreboard consumer: every seq_ce pulse must match the oldest acked word.
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (rst_n && seq_ce) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_load: seq_ce=1 with no acked word outstanding");
      end else begin
        e = sb.pop_front();
        checks++;
        if ({I, CCEN_BAR, D} !== {e.i, e.ccen, e.d}) begin
          errors++;
          $display("FAIL sb_word: got I=%0d CCEN_BAR=%b D=0x%03h, want I=%0d CCEN_BAR=%b D=0x%03h",
                   I, CCEN_BAR, D, e.i, e.ccen, e.d);
        end
        checks++;
        if (CC_BAR !== ~status[e.cc]) begin
          errors++;
          $display("FAIL sb_cc_bar: got %b, want %b (cc_sel=%0d)", CC_BAR, ~status[e.cc], e.cc);
        end
        checks++;
        if (uinst_valid !== 1'b1) begin
          errors++;
          $display("FAIL sb_valid: got %b, want 1", uinst_valid);
        end
      end
    end
  end

  task automatic test_reset();
    cyc();
    cyc();
    checks++;
    if ({mem_req, mem_addr, seq_ce, uinst_valid} !== {1'b0, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b addr=0x%03h ce=%b valid=%b, want 0 0x000 0 0",
               mem_req, mem_addr, seq_ce, uinst_valid);
    end
    checks++;
    if ({I, CCEN_BAR, D, CC_BAR} !== {4'd0, 1'b1, 12'h000, 1'b1}) begin
      errors++;
      $display("FAIL reset_word: got I=%0d CCEN_BAR=%b D=0x%03h CC_BAR=%b, want 0 1 0x000 1",
               I, CCEN_BAR, D, CC_BAR);
    end
`ifdef USEQ_FETCH_PARITY_EN
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_par_err: got %b, want 0", par_err);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 12'h000}) begin
      errors++;
      $display("FAIL basic_req: got req=%b addr=0x%03h, want 1 0x000", mem_req, mem_addr);
    end
    ack_word(3'd2, 1'b0, 4'd3, 12'h0A5);
    cyc();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, seq_ce} !== 2'b01) begin
      errors++;
      $display("FAIL basic_load: got req=%b ce=%b, want 0 1", mem_req, seq_ce);
    end
    y_addr = 12'h001;
    cyc();
    checks++;
    if ({seq_ce, mem_req, mem_addr, I} !== {1'b0, 1'b1, 12'h001, 4'd3}) begin
      errors++;
      $display("FAIL basic_next: got ce=%b req=%b addr=0x%03h I=%0d, want 0 1 0x001 3",
               seq_ce, mem_req, mem_addr, I);
    end
  endtask

  task automatic test_ack_delay();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_req, mem_addr, seq_ce} !== {1'b1, 12'h001, 1'b0}) begin
        errors++;
        $display("FAIL delay_wait%0d: got req=%b addr=0x%03h ce=%b, want 1 0x001 0",
                 k, mem_req, mem_addr, seq_ce);
      end
      if (k < 4) begin
        y_addr = 12'h7F0 + 12'(k);
        cyc();
      end
    end
    ack_word(3'd5, 1'b1, 4'd9, 12'h123);
    cyc();
    mem_ack = 1'b0;
    checks++;
    if (seq_ce !== 1'b1) begin
      errors++;
      $display("FAIL delay_load: got ce=%b, want 1", seq_ce);
    end
    y_addr = 12'h002;
    cyc();
    checks++;
    if ({seq_ce, mem_addr} !== {1'b0, 12'h002}) begin
      errors++;
      $display("FAIL delay_next: got ce=%b addr=0x%03h, want 0 0x002", seq_ce, mem_addr);
    end
  endtask

  task automatic test_cc_mux();
    status = 8'h20;
    #1;
    checks++;
    if (CC_BAR !== 1'b0) begin
      errors++;
      $display("FAIL cc_set: got CC_BAR=%b, want 0", CC_BAR);
    end
    status = 8'hDF;
    #1;
    checks++;
    if ({CC_BAR, seq_ce} !== 2'b10) begin
      errors++;
      $display("FAIL cc_clear: got CC_BAR=%b ce=%b, want 1 0", CC_BAR, seq_ce);
    end
    status = 8'h00;
  endtask

  task automatic test_hold();
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 12'h002}) begin
      errors++;
      $display("FAIL hold_req: got req=%b addr=0x%03h, want 1 0x002", mem_req, mem_addr);
    end
    hold = 1'b1;
    ack_word(3'd1, 1'b0, 4'd1, 12'h0F0);
    cyc();
    mem_ack = 1'b0;
    checks++;
    if (seq_ce !== 1'b1) begin
      errors++;
      $display("FAIL hold_load: got ce=%b, want 1", seq_ce);
    end
    y_addr = 12'h155;
    cyc();
    checks++;
    if ({mem_req, seq_ce} !== 2'b00) begin
      errors++;
      $display("FAIL hold_enter: got req=%b ce=%b, want 0 0", mem_req, seq_ce);
    end
    // Stray ack while not in REQ must be ignored.
    ack_word(3'd7, 1'b1, 4'd15, 12'hFFF);
    void'(sb.pop_back());
    cyc();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, seq_ce, I, D} !== {1'b0, 1'b0, 4'd1, 12'h0F0}) begin
      errors++;
      $display("FAIL hold_stray_ack: got req=%b ce=%b I=%0d D=0x%03h, want 0 0 1 0x0F0",
               mem_req, seq_ce, I, D);
    end
    y_addr = 12'h2AA;
    hold   = 1'b0;
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 12'h2AA}) begin
      errors++;
      $display("FAIL hold_release: got req=%b addr=0x%03h, want 1 0x2AA", mem_req, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] nxt[3] = '{12'h2AB, 12'h800, 12'hFFF};
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = 12'h2AA;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
        errors++;
        $display("FAIL b2b_req%0d: got req=%b addr=0x%03h, want 1 0x%03h",
                 n, mem_req, mem_addr, exp_addr);
      end
      ack_word(3'(n), 1'(n), 4'(n + 4), 12'h100 + 12'(n));
      cyc();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, seq_ce} !== 2'b01) begin
        errors++;
        $display("FAIL b2b_load%0d: got req=%b ce=%b, want 0 1", n, mem_req, seq_ce);
      end
      y_addr   = nxt[n];
      exp_addr = nxt[n];
      cyc();
    end
  endtask

  task automatic test_reset_mid_req();
    #3;
    rst_n  = 1'b0;
    y_addr = 12'h000;
    #1;
    checks++;
    if ({mem_req, I, seq_ce, uinst_valid} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_req: got req=%b I=%0d ce=%b valid=%b, want 0 0 0 0",
               mem_req, I, seq_ce, uinst_valid);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 12'h000}) begin
      errors++;
      $display("FAIL rst_refetch: got req=%b addr=0x%03h, want 1 0x000", mem_req, mem_addr);
    end
  endtask

`ifdef USEQ_FETCH_PARITY_EN
  task automatic test_parity();
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_clean: got par_err=%b, want 0", par_err);
    end
    mem_ack   = 1'b1;
    mem_rdata = mk(3'd3, 1'b0, 4'd3, 12'h5A5);
    mem_rdata[RD_W-1] = ~mem_rdata[RD_W-1];
    sb.push_back('{i: 4'd14, ccen: 1'b1, cc: 3'd0, d: 12'h000});
    cyc();
    mem_ack = 1'b0;
    checks++;
    if ({seq_ce, par_err} !== 2'b11) begin
      errors++;
      $display("FAIL par_bad: got ce=%b par_err=%b, want 1 1", seq_ce, par_err);
    end
    y_addr = 12'h010;
    cyc();
    ack_word(3'd4, 1'b0, 4'd12, 12'h00F);
    cyc();
    mem_ack = 1'b0;
    checks++;
    if ({seq_ce, par_err} !== 2'b11) begin
      errors++;
      $display("FAIL par_sticky: got ce=%b par_err=%b, want 1 1", seq_ce, par_err);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_reset: got par_err=%b, want 0", par_err);
    end
    cyc();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    y_addr    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    status    = 8'h00;
    hold      = 1'b0;
    test_reset();
    test_basic_fetch();
    test_ack_delay();
    test_cc_mux();
    test_hold();
    test_back_to_back();
    test_reset_mid_req();
`ifdef USEQ_FETCH_PARITY_EN
    test_parity();
`endif
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d words never loaded, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
